// File: rtl/lfsr_pkg.sv
// Shared types, defaults and the XNOR feedback helper for the shift-right LFSR family.
package lfsr_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int WIDTH_DEF      = 4;
    localparam int TAP_A_DEF      = 3;
    localparam int TAP_B_DEF      = 0;
    localparam int LOCK_COUNT_DEF = 8;
    localparam int LOSS_COUNT_DEF = 3;
    localparam int ERRCNT_W       = 16;

    // Widest register lfsr_fb accepts; narrower states are zero-extended by the caller.
    localparam int LFSR_MAX_W = 32;

    function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] state,
                                     input logic [4:0]            tap_a,
                                     input logic [4:0]            tap_b);
        return state[tap_a] ~^ state[tap_b];
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_predictor.sv
// History register, fill counter and next-bit prediction for a shift-right XNOR LFSR stream.
module lfsr_predictor
    import lfsr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAP_A = TAP_A_DEF,
    parameter int TAP_B = TAP_B_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             shift_en,
    input  logic             new_bit,
    input  logic             fill_clr,
    output logic [WIDTH-1:0] h,
    output logic             pred,
    output logic             filled
);

    localparam int FILL_W = $clog2(WIDTH + 1);

    logic [FILL_W-1:0] fill_cnt;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            h        <= '0;
            fill_cnt <= '0;
        end else begin
            if (shift_en) begin
                h <= {new_bit, h[WIDTH-1:1]};
            end
            if (fill_clr) begin
                fill_cnt <= '0;
            end else if (shift_en && !filled) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    assign filled = (fill_cnt == FILL_W'(WIDTH));
    assign pred   = lfsr_fb(LFSR_MAX_W'(h), 5'(TAP_A), 5'(TAP_B));

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for shift-right XNOR LFSR streams; flywheels once locked.
// Define LFSR_CHK_ERRCNT_EN to build the saturating ErrCount and its Clear input.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int TAP_A      = TAP_A_DEF,
    parameter int TAP_B      = TAP_B_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Valid,
    input  logic                DataIn,
    input  logic                Clear,
    output logic                Locked,
    output logic                Error,
    output logic [ERRCNT_W-1:0] ErrCount
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    chk_state_t         state;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;

    logic [WIDTH-1:0] h;
    logic             pred;
    logic             filled;
    logic             new_bit;
    logic             bit_match;
    logic             lockup;
    logic             err_hit;
    logic             drop_lock;

    lfsr_predictor #(
        .WIDTH (WIDTH),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_predictor (
        .Clock    (Clock),
        .Reset    (Reset),
        .shift_en (Valid),
        .new_bit  (new_bit),
        .fill_clr (drop_lock),
        .h        (h),
        .pred     (pred),
        .filled   (filled)
    );

    // NOTE: every signal gets a default at the top of always_comb so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        new_bit   = DataIn;
        bit_match = (DataIn == pred);
        lockup    = &h;
        err_hit   = 1'b0;
        drop_lock = 1'b0;
        if (state == LOCKED) begin
            // Flywheel: the predictor feeds itself, so a single bad bit cannot poison h.
            new_bit   = pred;
            err_hit   = Valid && !bit_match;
            drop_lock = err_hit && (miss_cnt == MISS_W'(LOSS_COUNT - 1));
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= SEARCH;
            match_cnt <= '0;
            miss_cnt  <= '0;
            Locked    <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Error <= 1'b0;
            if (Valid) begin
                case (state)
                    SEARCH: begin
                        if (filled) begin
                            // A match inside the all-ones lockup state proves nothing.
                            if (bit_match && !lockup) begin
                                if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                                    state     <= LOCKED;
                                    Locked    <= 1'b1;
                                    match_cnt <= '0;
                                    miss_cnt  <= '0;
                                end else begin
                                    match_cnt <= match_cnt + 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (err_hit) begin
                            Error <= 1'b1;
                            if (drop_lock) begin
                                state     <= SEARCH;
                                Locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        Locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_ERRCNT_EN
    // Clear is checked first so it wins over a same-cycle increment.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ErrCount <= '0;
        end else if (Clear) begin
            ErrCount <= '0;
        end else if (err_hit && (ErrCount != '1)) begin
            ErrCount <= ErrCount + 1'b1;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = Clear;
    assign ErrCount     = '0;
`endif

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Serial receive-side checker for the team's shift-right XNOR LFSR generators. Takes the generator's output bit (state bit 0) one bit per valid cycle, self-synchronises a local predictor to the stream, then flywheels and flags every bit that deviates from the expected sequence. It sits at the consuming end of any LFSR-driven link, such as the computer-player or test-pattern paths, to prove the stream is intact.

## Interface
- WIDTH, 4, LFSR length in bits
- TAP_A, 3, first feedback tap index
- TAP_B, 0, second feedback tap index; the default pair gives a maximal period of 15
- LOCK_COUNT, 8, consecutive matches needed to declare lock
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low (Reset=0 resets immediately)
- Valid  in  1  DataIn is meaningful this cycle
- DataIn  in  1  received stream bit
- Clear  in  1  synchronous clear of ErrCount
- Locked  out  1  predictor is in lock
- Error  out  1  one-cycle pulse per mismatched bit while locked
- ErrCount  out  16  saturating count of mismatches while locked

## Operation
- History register h[WIDTH-1:0] holds the last WIDTH bits, with h[0] the oldest. The prediction is pred = h[TAP_A] ~^ h[TAP_B]. Every accepted bit shifts h <= {newbit, h[WIDTH-1:1]}.
- FSM states are SEARCH and LOCKED.
- SEARCH:
  - newbit = DataIn.
  - The first WIDTH valid bits after entry only fill h. A fill counter tracks them; no comparison is made.
  - After fill, each valid bit is compared with pred. A match increments the match counter; a mismatch zeroes it.
  - A match while h is all ones (the XNOR lockup state) also zeroes the match counter.
  - When the match counter reaches LOCK_COUNT, go to LOCKED.
  - Error never asserts in SEARCH.
- LOCKED:
  - newbit = pred (flywheel), so one corrupted bit produces exactly one Error.
  - A mismatch pulses Error, increments ErrCount (saturating at 16'hFFFF), and increments the miss counter.
  - A match zeroes the miss counter.
  - When the miss counter reaches LOSS_COUNT, go to SEARCH. The fill, match and miss counters are zeroed.
- Valid=0: no state, counter or h change, and Error=0.
- Clear=1 zeroes ErrCount. If Clear and an error increment land in the same cycle, Clear wins and ErrCount=0.
- Reset: h=0, all counters=0, state=SEARCH, Locked=0, Error=0, ErrCount=0.

## Timing
- All outputs are registered.
- Error is high the cycle after the mismatched Valid bit.
- Locked rises the cycle after the LOCK_COUNT-th consecutive match. From reset with a clean stream, that is the cycle after valid bit WIDTH+LOCK_COUNT (bit 12 with the defaults).
- Locked falls the cycle after the LOSS_COUNT-th consecutive mismatch. Error is also high that cycle.
- Reset asserted mid-operation clears every output asynchronously. After release, operation restarts from SEARCH with an empty fill.

## Configuration
- LFSR_CHK_ERRCNT_EN defined: the 16-bit saturating ErrCount and its Clear logic are built.
- Not defined: ErrCount is tied to 0 and Clear is ignored. Error and Locked behave identically in both cases.

## Structure
- Package lfsr_pkg holds:
  - the state enum typedef (SEARCH, LOCKED)
  - default WIDTH, tap and count constants
  - ERRCNT_W = 16
  - function lfsr_fb(state, tap_a, tap_b), returning the XNOR feedback
- Sub-module lfsr_predictor: owns h, the fill counter and pred. It is shared with future generator-side blocks.
- The top-level module holds the FSM and the counters.

## Test plan
Default parameters throughout. One period of the clean stream from a 0000 generator seed is 0,0,0,0,1,0,1,0,0,1,1,0,1,1,1, repeated.
- Reset, then feed the clean stream with Valid=1 continuously -> Locked=1 the cycle after bit 12; Error never asserts; ErrCount=0.
- Once locked, invert one bit -> a single Error pulse the next cycle; ErrCount=1; Locked stays 1.
- Once locked, invert 3 consecutive bits -> Error high 3 cycles; Locked=0 after the 3rd; ErrCount=3. The clean stream then relocks after 12 more valid bits.
- Feed 40 bits of all ones -> Locked never asserts.
- Feed the clean stream with Valid alternating 1/0 -> Locked after the 12th valid bit, the 24th cycle; no Error pulses.
- Assert Reset mid-lock with ErrCount=5 -> Locked, Error and ErrCount are all 0 immediately.
- With LFSR_CHK_ERRCNT_EN undefined, repeat the single-bit-error scenario -> Error pulses and ErrCount stays 0.
